// File: rtl/lfsr_period_monitor_pkg.sv
// Shared definitions for the LFSR period monitor and the LFSR benches:
// FSM state encoding, default LFSR width and the default LFSR seed.
package lfsr_period_monitor_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } mon_state_e;

   localparam int          LFSR_WIDTH = 16;
   localparam logic [15:0] LFSR_SEED  = 16'b1010110011100001;

endpackage : lfsr_period_monitor_pkg

// File: rtl/lfsr_period_monitor.sv
// LFSR period monitor: captures the first valid sample as the seed, counts
// samples until the seed recurs and reports the period plus the number of
// ones seen on the MSB keystream bit. Flags all-zero lock-up and a timeout
// when the seed does not recur within 2^WIDTH samples.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | after reset; samples ignored, waiting for start
// ST_ARMED | waiting for the first valid sample, which becomes the seed
// ST_RUN   | counting samples until seed recurs, zero state, or timeout
// ST_DONE  | results held until the next start; samples ignored
module lfsr_period_monitor
   import lfsr_period_monitor_pkg::*;
#(
   parameter  int WIDTH = LFSR_WIDTH,
   localparam int CNT_W = WIDTH + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             state_valid,
   input  logic [WIDTH:1]   state_in,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] ones_count,
   output logic             lockup,
   output logic             timeout,
   output logic [WIDTH:1]   seed_cap
);

   // 2^WIDTH: the sample count at which the seed is declared lost. CNT_W
   // is one bit wider than WIDTH so this value is representable.
   localparam logic [CNT_W-1:0] CNT_LIMIT = {1'b1, {WIDTH{1'b0}}};

   mon_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] ones_q, ones_d;
   logic             lockup_q, lockup_d;
   logic             timeout_q, timeout_d;
   logic [WIDTH:1]   seed_q, seed_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] cnt_next;
   logic [CNT_W-1:0] msb_ext;

   assign cnt_next = cnt_q + CNT_W'(1);
   assign msb_ext  = CNT_W'(state_in[WIDTH]);

   // Next-state and result update; start overrides everything, including a
   // coincident valid sample.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      period_d  = period_q;
      ones_d    = ones_q;
      lockup_d  = lockup_q;
      timeout_d = timeout_q;
      seed_d    = seed_q;

      if (start) begin
         state_d   = ST_ARMED;
         cnt_d     = '0;
         period_d  = '0;
         ones_d    = '0;
         lockup_d  = 1'b0;
         timeout_d = 1'b0;
         seed_d    = '0;
      end else begin
         case (state_q)
            ST_ARMED: begin
               if (state_valid) begin
                  seed_d = state_in;
                  cnt_d  = '0;
                  ones_d = msb_ext;
                  if (state_in == '0) begin
                     lockup_d = 1'b1;
                     period_d = '0;
                     state_d  = ST_DONE;
                  end else begin
                     state_d  = ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               if (state_valid) begin
                  if (state_in == seed_q) begin
                     period_d = cnt_next;
                     state_d  = ST_DONE;
                  end else if (state_in == '0) begin
                     lockup_d = 1'b1;
                     period_d = '0;
                     state_d  = ST_DONE;
                  end else if (cnt_next == CNT_LIMIT) begin
                     timeout_d = 1'b1;
                     period_d  = '0;
                     state_d   = ST_DONE;
                  end else begin
                     cnt_d  = cnt_next;
                     ones_d = ones_q + msb_ext;
                  end
               end
            end
            default: begin
            end
         endcase
      end

      busy_d = (state_d == ST_ARMED) || (state_d == ST_RUN);
      done_d = (state_d == ST_DONE);
   end

   // State and result registers, cleared asynchronously by reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         period_q  <= '0;
         ones_q    <= '0;
         lockup_q  <= 1'b0;
         timeout_q <= 1'b0;
         seed_q    <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         period_q  <= period_d;
         ones_q    <= ones_d;
         lockup_q  <= lockup_d;
         timeout_q <= timeout_d;
         seed_q    <= seed_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign period     = period_q;
   assign ones_count = ones_q;
   assign lockup     = lockup_q;
   assign timeout    = timeout_q;
   assign seed_cap   = seed_q;

endmodule : lfsr_period_monitor

// File: tb/tb_lfsr_period_monitor.sv
// Directed bench for lfsr_period_monitor. Two instances share clock and
// reset so the full-period run and the timeout run overlap in time.
module tb_lfsr_period_monitor;
   import lfsr_period_monitor_pkg::*;

   localparam int W = 16;
   localparam int C = W + 1;

   logic         clock = 1'b0;
   logic         reset = 1'b0;

   logic         start_a = 1'b0, valid_a = 1'b0;
   logic [W:1]   sin_a = '0;
   logic         busy_a, done_a, lockup_a, timeout_a;
   logic [C-1:0] period_a, ones_a;
   logic [W:1]   seed_a;

   logic         start_b = 1'b0, valid_b = 1'b0;
   logic [W:1]   sin_b = '0;
   logic         busy_b, done_b, lockup_b, timeout_b;
   logic [C-1:0] period_b, ones_b;
   logic [W:1]   seed_b;

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   lfsr_period_monitor #(.WIDTH(W)) u_dut_a (
      .clock(clock), .reset(reset), .start(start_a), .state_valid(valid_a),
      .state_in(sin_a), .busy(busy_a), .done(done_a), .period(period_a),
      .ones_count(ones_a), .lockup(lockup_a), .timeout(timeout_a),
      .seed_cap(seed_a)
   );

   lfsr_period_monitor #(.WIDTH(W)) u_dut_b (
      .clock(clock), .reset(reset), .start(start_b), .state_valid(valid_b),
      .state_in(sin_b), .busy(busy_b), .done(done_b), .period(period_b),
      .ones_count(ones_b), .lockup(lockup_b), .timeout(timeout_b),
      .seed_cap(seed_b)
   );

   // Maximal-length 16-bit LFSR x^16+x^14+x^13+x^11+1, right-shifting form.
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      logic fb;
      fb = s[0] ^ s[2] ^ s[3] ^ s[5];
      return {fb, s[15:1]};
   endfunction

   task automatic pulse_start_a();
      @(negedge clock); start_a = 1'b1; valid_a = 1'b0;
      @(negedge clock); start_a = 1'b0;
   endtask

   task automatic feed_a(input logic [15:0] v, input int gap);
      @(negedge clock); valid_a = 1'b1; sin_a = v;
      @(negedge clock); valid_a = 1'b0;
      repeat (gap) @(negedge clock);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clock);
      checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_a); end
      checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done_a); end
      checks++; if (period_a !== '0 || ones_a !== '0) begin errors++; $display("FAIL reset_counts: period %0d ones %0d want 0 0", period_a, ones_a); end
      checks++; if (lockup_a !== 1'b0 || timeout_a !== 1'b0 || seed_a !== '0) begin errors++; $display("FAIL reset_flags: lockup %b timeout %b seed %h want 0 0 0000", lockup_a, timeout_a, seed_a); end
      reset = 1'b1;
      @(negedge clock);
      checks++; if (busy_b !== 1'b0 || done_b !== 1'b0) begin errors++; $display("FAIL reset_b: busy %b done %b want 0 0", busy_b, done_b); end
   endtask

   task automatic test_full_period();
      logic [15:0] lfsr;
      int n;
      pulse_start_a();
      checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL armed_busy: got %b want 1", busy_a); end
      lfsr = LFSR_SEED;
      n = 0;
      for (int i = 0; i < 70000; i++) begin
         if (done_a) break;
         valid_a = 1'b1; sin_a = lfsr;
         lfsr = lfsr_next(lfsr);
         n++;
         @(negedge clock);
      end
      valid_a = 1'b0;
      checks++; if (done_a !== 1'b1 || n !== 65536) begin errors++; $display("FAIL full_latency: done %b after %0d samples want 1 after 65536", done_a, n); end
      checks++; if (period_a !== C'(65535)) begin errors++; $display("FAIL full_period: got %0d want 65535", period_a); end
      checks++; if (ones_a !== C'(32768)) begin errors++; $display("FAIL full_ones: got %0d want 32768", ones_a); end
      checks++; if (lockup_a !== 1'b0 || timeout_a !== 1'b0 || busy_a !== 1'b0) begin errors++; $display("FAIL full_flags: lockup %b timeout %b busy %b want 0 0 0", lockup_a, timeout_a, busy_a); end
      checks++; if (seed_a !== 16'hACE1) begin errors++; $display("FAIL full_seed: got %h want ace1", seed_a); end
   endtask

   task automatic test_timeout();
      int n;
      @(negedge clock); start_b = 1'b1;
      @(negedge clock); start_b = 1'b0; valid_b = 1'b1; sin_b = 16'h1234;
      @(negedge clock); sin_b = 16'h5678;
      n = 0;
      for (int i = 0; i < 70000; i++) begin
         if (done_b) break;
         n++;
         @(negedge clock);
      end
      valid_b = 1'b0;
      checks++; if (done_b !== 1'b1 || n !== 65536) begin errors++; $display("FAIL timeout_latency: done %b after %0d post-seed samples want 1 after 65536", done_b, n); end
      checks++; if (timeout_b !== 1'b1 || period_b !== '0 || lockup_b !== 1'b0) begin errors++; $display("FAIL timeout_flags: timeout %b period %0d lockup %b want 1 0 0", timeout_b, period_b, lockup_b); end
      checks++; if (seed_b !== 16'h1234) begin errors++; $display("FAIL timeout_seed: got %h want 1234", seed_b); end
   endtask

   task automatic test_lockup_first();
      pulse_start_a();
      checks++; if (period_a !== '0 || done_a !== 1'b0) begin errors++; $display("FAIL start_clears: period %0d done %b want 0 0", period_a, done_a); end
      feed_a(16'h0000, 0);
      checks++; if (done_a !== 1'b1 || lockup_a !== 1'b1 || busy_a !== 1'b0) begin errors++; $display("FAIL lock0_flags: done %b lockup %b busy %b want 1 1 0", done_a, lockup_a, busy_a); end
      checks++; if (period_a !== '0 || timeout_a !== 1'b0) begin errors++; $display("FAIL lock0_period: period %0d timeout %b want 0 0", period_a, timeout_a); end
   endtask

   task automatic test_gaps();
      logic [15:0] seq [4];
      seq = '{16'h8001, 16'h0002, 16'h8004, 16'h8001};
      for (int g = 0; g <= 5; g += 5) begin
         pulse_start_a();
         checks++; if (lockup_a !== 1'b0 || period_a !== '0) begin errors++; $display("FAIL gap%0d_clear: lockup %b period %0d want 0 0", g, lockup_a, period_a); end
         for (int k = 0; k < 3; k++) feed_a(seq[k], g);
         checks++; if (done_a !== 1'b0 || busy_a !== 1'b1) begin errors++; $display("FAIL gap%0d_early: done %b busy %b want 0 1", g, done_a, busy_a); end
         feed_a(seq[3], g);
         checks++; if (done_a !== 1'b1 || period_a !== C'(3)) begin errors++; $display("FAIL gap%0d_period: done %b period %0d want 1 3", g, done_a, period_a); end
         checks++; if (ones_a !== C'(2) || seed_a !== 16'h8001) begin errors++; $display("FAIL gap%0d_ones: ones %0d seed %h want 2 8001", g, ones_a, seed_a); end
      end
      feed_a(16'h0002, 0);
      feed_a(16'h8001, 0);
      checks++; if (done_a !== 1'b1 || period_a !== C'(3) || ones_a !== C'(2)) begin errors++; $display("FAIL done_hold: done %b period %0d ones %0d want 1 3 2", done_a, period_a, ones_a); end
   endtask

   task automatic test_lockup_mid();
      pulse_start_a();
      feed_a(16'h0001, 0);
      feed_a(16'h0002, 0);
      checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL lockmid_early: done %b want 0", done_a); end
      feed_a(16'h0000, 0);
      checks++; if (done_a !== 1'b1 || lockup_a !== 1'b1 || period_a !== '0) begin errors++; $display("FAIL lockmid_flags: done %b lockup %b period %0d want 1 1 0", done_a, lockup_a, period_a); end
      checks++; if (seed_a !== 16'h0001 || timeout_a !== 1'b0) begin errors++; $display("FAIL lockmid_seed: seed %h timeout %b want 0001 0", seed_a, timeout_a); end
   endtask

   task automatic test_abort();
      logic [15:0] lfsr;
      pulse_start_a();
      lfsr = LFSR_SEED;
      for (int i = 0; i < 1000; i++) begin
         valid_a = 1'b1; sin_a = lfsr; lfsr = lfsr_next(lfsr);
         @(negedge clock);
      end
      reset = 1'b0;
      #1;
      checks++; if (busy_a !== 1'b0 || seed_a !== '0 || ones_a !== '0) begin errors++; $display("FAIL abort_async: busy %b seed %h ones %0d want 0 0000 0", busy_a, seed_a, ones_a); end
      @(negedge clock); reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         valid_a = 1'b1; sin_a = lfsr; lfsr = lfsr_next(lfsr);
         @(negedge clock);
      end
      valid_a = 1'b0;
      checks++; if (busy_a !== 1'b0 || done_a !== 1'b0 || seed_a !== '0 || period_a !== '0) begin errors++; $display("FAIL abort_idle: busy %b done %b seed %h period %0d want 0 0 0000 0", busy_a, done_a, seed_a, period_a); end
      pulse_start_a();
      feed_a(16'h8001, 0);
      feed_a(16'h8002, 0);
      @(negedge clock); start_a = 1'b1; valid_a = 1'b1; sin_a = 16'hBEEF;
      @(negedge clock); start_a = 1'b0;
      checks++; if (seed_a !== '0 || busy_a !== 1'b1 || ones_a !== '0) begin errors++; $display("FAIL restart_clear: seed %h busy %b ones %0d want 0000 1 0", seed_a, busy_a, ones_a); end
      sin_a = 16'h4321;
      @(negedge clock); valid_a = 1'b0;
      checks++; if (seed_a !== 16'h4321 || busy_a !== 1'b1 || ones_a !== '0) begin errors++; $display("FAIL restart_seed: seed %h busy %b ones %0d want 4321 1 0", seed_a, busy_a, ones_a); end
   endtask

   initial begin
      test_reset();
      fork
         test_full_period();
         test_timeout();
      join
      test_lockup_first();
      test_gaps();
      test_lockup_mid();
      test_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_lfsr_period_monitor
